// File: rtl/delay_echo_core_pkg.sv
// Shared definitions for the echo datapath: default widths, control encoding
// and the saturating narrow used on both sum paths.
package dsp_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 12;
  localparam int GW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } ctrl_state_t;

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [31:0] sat_dw(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/delay_echo_if.sv
// Sample handshake, run-time controls and processed-sample outputs of the echo core.
interface delay_echo_if
  import dsp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int GW = GW_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_sample;
  logic [AW-1:0]        delay;
  logic [GW-1:0]        fb_gain;
  logic [GW-1:0]        mix_gain;
  logic                 bypass;
  logic                 out_valid;
  logic signed [DW-1:0] out_sample;
  logic                 primed;

  modport master (
    output in_valid, in_sample, delay, fb_gain, mix_gain, bypass,
    input  in_ready, out_valid, out_sample, primed
  );

  modport slave (
    input  in_valid, in_sample, delay, fb_gain, mix_gain, bypass,
    output in_ready, out_valid, out_sample, primed
  );
endinterface

// File: rtl/delay_echo_core_sdp_ram.sv
// Simple dual-port RAM holding the delay line: one write port, one registered read port.
module sdp_ram #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/delay_echo_core.sv
// Feedback echo over a circular buffer with run-time delay, feedback gain, wet mix and bypass.
// One sample every three cycles; the buffer read is issued at accept, the write at completion.
module delay_echo_core
  import dsp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int GW = GW_DEF
) (
  input logic         clk,
  input logic         rst,
  delay_echo_if.slave bus
);
  // state | meaning
  // IDLE  | ready; accept captures the sample and controls, issues the buffer read
  // RD    | buffer read data returns and is registered as d
  // WR    | sums formed, output strobed, buffer written, pointer and fill advance

  localparam logic [AW:0] FILL_MAX = {1'b1, {AW{1'b0}}};
  localparam int PW = DW + GW + 1;
  localparam int SW = DW + 2;

  ctrl_state_t          state;
  logic [AW-1:0]        wr_ptr, delay_eff, deff_q, rd_addr;
  logic [AW:0]          fill_cnt;
  logic signed [DW-1:0] x_q, d, w, rd_data, out_q, out_next, wr_data;
  logic [GW-1:0]        fb_q, mix_q;
  logic                 byp_q, out_valid_q, accept, wet_ok, wr_en;
  logic signed [PW-1:0] fb_prod, mix_prod;
  logic signed [SW-1:0] fb_sum, mix_sum;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign delay_eff = (bus.delay == '0) ? AW'(1) : bus.delay;
  assign rd_addr   = wr_ptr - delay_eff;
  assign wr_en     = (state == WR);

  // Data older than the post-reset fill is stale or unwritten, so the wet term is gated.
  assign wet_ok = fill_cnt >= {1'b0, deff_q};
  assign w      = wet_ok ? d : '0;

  assign fb_prod  = PW'(w) * PW'($signed({1'b0, fb_q}));
  assign mix_prod = PW'(w) * PW'($signed({1'b0, mix_q}));
  assign fb_sum   = SW'(x_q) + SW'(fb_prod >>> GW);
  assign mix_sum  = SW'(x_q) + SW'(mix_prod >>> GW);
  assign wr_data  = byp_q ? x_q : DW'(sat_dw(32'(fb_sum), DW));
  assign out_next = byp_q ? x_q : DW'(sat_dw(32'(mix_sum), DW));

  sdp_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (accept),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      deff_q      <= AW'(1);
      x_q         <= '0;
      d           <= '0;
      fb_q        <= '0;
      mix_q       <= '0;
      byp_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x_q    <= bus.in_sample;
            deff_q <= delay_eff;
            fb_q   <= bus.fb_gain;
            mix_q  <= bus.mix_gain;
            byp_q  <= bus.bypass;
            state  <= RD;
          end
        end
        RD: begin
          d     <= rd_data;
          state <= WR;
        end
        WR: begin
          out_q       <= out_next;
          out_valid_q <= 1'b1;
          wr_ptr      <= wr_ptr + AW'(1);
          if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_q;
  assign bus.primed     = wet_ok;
endmodule

// File: tb/tb_delay_echo_core.sv
// Bench for delay_echo_core (16-entry buffer): a history-of-writes model predicts every
// output, with literal expectations on impulse, decay, saturation, wrap, handshake and reset.
module tb_delay_echo_core;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int GW = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_echo_if #(.DW(DW), .AW(AW), .GW(GW)) bus ();
  delay_echo_core #(.DW(DW), .AW(AW), .GW(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int val;
    int acc;
    bit primed;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   outs[$];
  int   nw = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int floor_div256(input int p);
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction

  function automatic int sat16(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  // The wet term is whatever was written delay_eff samples ago, once that many exist.
  task automatic model_accept(input int x, input int dly, input int fb, input int mix, input bit byp);
    int de, fill, w, o, wr;
    exp_t e;
    de   = (dly == 0) ? 1 : dly;
    fill = (nw > DEPTH) ? DEPTH : nw;
    w    = (fill >= de) ? hist[nw - de] : 0;
    if (byp) begin
      o  = x;
      wr = x;
    end else begin
      o  = sat16(x + floor_div256(w * mix));
      wr = sat16(x + floor_div256(w * fb));
    end
    hist.push_back(wr);
    nw++;
    e.val    = o;
    e.acc    = cyc + 1;
    e.primed = (((nw > DEPTH) ? DEPTH : nw) >= de);
    exp_q.push_back(e);
  endtask

  task automatic compare_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_sample", int'(bus.out_sample), e.val);
          chk("latency", cyc - e.acc, 2);
          chk("primed at output", int'(bus.primed), int'(e.primed));
          outs.push_back(int'(bus.out_sample));
        end
      end
    end
  endtask

  task automatic send(input int x, input int dly, input int fb, input int mix, input bit byp);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sample = DW'(x);
    bus.delay     = AW'(dly);
    bus.fb_gain   = GW'(fb);
    bus.mix_gain  = GW'(mix);
    bus.bypass    = byp;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready wait", 0, 1);
    end else begin
      model_accept(x, dly, fb, mix, byp);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("pending outputs", exp_q.size(), 0);
  endtask

  initial begin
    int b, acc, acc_mask;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.delay = '0;
    bus.fb_gain = '0;
    bus.mix_gain = '0;
    bus.bypass = 1'b0;
    #1 rst = 1'b1;
    #20;
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_sample", int'(bus.out_sample), 0);
    chk("reset primed", int'(bus.primed), 0);
    @(negedge clk) rst = 1'b0;

    fork
      compare_loop();
    join_none

    // Impulse through a 4-sample delay, no feedback
    b = outs.size();
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 1000 : 0, 4, 0, 255, 1'b0);
      if (i == 2) begin drain(); chk("primed after 3", int'(bus.primed), 0); end
      if (i == 3) begin drain(); chk("primed after 4", int'(bus.primed), 1); end
    end
    drain();
    chk("impulse out0", outs[b], 1000);
    chk("impulse out1", outs[b+1], 0);
    chk("impulse out3", outs[b+3], 0);
    chk("impulse echo", outs[b+4], 996);
    chk("impulse out8", outs[b+7], 0);

    // Feedback decay, delay 2, half feedback
    b = outs.size();
    for (int i = 0; i < 8; i++) send((i == 0) ? 8192 : 0, 2, 128, 255, 1'b0);
    drain();
    chk("decay dry", outs[b], 8192);
    chk("decay gap", outs[b+1], 0);
    chk("decay echo1", outs[b+2], 8160);
    chk("decay echo2", outs[b+4], 4080);
    chk("decay echo3", outs[b+6], 2040);

    // Saturation both ways with delay 1 and near-unity gains
    b = outs.size();
    for (int i = 0; i < 4; i++) send(30000, 1, 255, 255, 1'b0);
    for (int i = 0; i < 4; i++) send(-30000, 1, 255, 255, 1'b0);
    drain();
    chk("sat first", outs[b], 30000);
    chk("sat pos", outs[b+1], 32767);
    chk("sat pos hold", outs[b+3], 32767);
    chk("sat neg", outs[b+6], -32768);
    chk("sat neg hold", outs[b+7], -32768);

    // Ramp across pointer wrap with maximum delay, then delay 0 and a decrease
    b = outs.size();
    for (int k = 0; k <= 40; k++) send(k, 15, 0, 255, 1'b0);
    send(100, 0, 0, 255, 1'b0);
    send(200, 0, 0, 255, 1'b0);
    send(300, 3, 0, 255, 1'b0);
    drain();
    chk("ramp k20", outs[b+20], 24);
    chk("ramp k32", outs[b+32], 48);
    chk("ramp k35", outs[b+35], 54);
    chk("delay0 first", outs[b+41], 139);
    chk("delay0 second", outs[b+42], 299);

    // in_valid held for 10 cycles in bypass
    b = outs.size();
    acc = 0;
    acc_mask = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.delay = AW'(5);
    bus.fb_gain = GW'(200);
    bus.mix_gain = GW'(200);
    bus.bypass = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_sample = DW'(100 * i + 7);
      if (bus.in_ready) begin
        acc++;
        acc_mask |= (1 << i);
        model_accept(100 * i + 7, 5, 200, 200, 1'b1);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.bypass = 1'b0;
    drain();
    chk("accept count", acc, 4);
    chk("accept cycles", acc_mask, 32'h249);
    chk("bypass s0", outs[b], 7);
    chk("bypass s3", outs[b+3], 907);

    // Async reset one cycle into a sample
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sample = DW'(1234);
    bus.delay = AW'(3);
    bus.fb_gain = GW'(0);
    bus.mix_gain = GW'(255);
    @(posedge clk);
    @(negedge clk) bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    hist.delete();
    nw = 0;
    #1;
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst out_sample", int'(bus.out_sample), 0);
    chk("midrst in_ready", int'(bus.in_ready), 1);
    chk("midrst primed", int'(bus.primed), 0);
    repeat (3) @(negedge clk);
    chk("flushed out_valid", int'(bus.out_valid), 0);
    rst = 1'b0;

    b = outs.size();
    for (int i = 0; i < 5; i++) send((i == 0) ? 500 : 0, 3, 0, 255, 1'b0);
    drain();
    chk("refill gated0", outs[b], 500);
    chk("refill gated2", outs[b+2], 0);
    chk("refill echo", outs[b+3], 498);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, required finished");
    $fatal(1, "timeout");
  end
endmodule
